// File: rtl/nn_seq_ctrl.sv
// rtl/nn_seq_ctrl.sv - tile/layer sequencer for the NN load and layer engines
//
// Purpose: walks NUM_TILES weight/input loads per layer, then one layering
// pass, for NUM_LAYERS layers per accepted start. Every wait on an engine
// busy handshake is bounded by TIMEOUT cycles; an expired wait parks the
// sequencer in ERROR until the next start.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, abort              kick off a run / drop back to idle
//   valid_ctrl_busy           busy handshake of the load/valid pipeline
//   layer_ctrl_busy           busy handshake of the layer engine
//   next_tile_ready           load side can accept the next tile
//   start_weights, start_input, start_valid_pipeline
//                             one-cycle load pulses, issued together
//   start_layering            one-cycle layer pulse
//   next_tile                 one-cycle advance-tile pulse
//   done                      one-cycle end-of-run pulse
//   busy                      sequencer not idle
//   error                     sticky timeout flag
//   mode                      0 idle, 1 load, 2 layer, 3 error
//   tile_idx, layer_idx       current tile and layer

module nn_seq_ctrl #(
  parameter int N          = 8,
  parameter int TILE       = 4,
  parameter int NUM_LAYERS = 2,
  parameter int TIMEOUT    = 1024,
  localparam int NUM_TILES = N / TILE,
  localparam int TW        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
  localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          valid_ctrl_busy,
  input  logic          layer_ctrl_busy,
  input  logic          next_tile_ready,
  output logic          start_weights,
  output logic          start_input,
  output logic          start_valid_pipeline,
  output logic          start_layering,
  output logic          next_tile,
  output logic          done,
  output logic          busy,
  output logic          error,
  output logic [2:0]    mode,
  output logic [TW-1:0] tile_idx,
  output logic [LW-1:0] layer_idx
);

  typedef enum logic [3:0] {
    IDLE,
    ISSUE_LOAD,
    WAIT_LOAD_ON,
    WAIT_LOAD_OFF,
    NEXT_LOAD_TILE,
    ISSUE_LAYER,
    WAIT_LAY_ON,
    WAIT_LAY_OFF,
    NEXT_LAYER,
    DONE,
    ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tile_q, tile_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_q, load_d;
  logic          lay_q, lay_d;
  logic          next_q, next_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          error_q, error_d;
  logic [2:0]    mode_q, mode_d;
  logic          timed_out;
  logic          in_wait;

  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
  assign in_wait   = (state_q inside {WAIT_LOAD_ON, WAIT_LOAD_OFF, WAIT_LAY_ON, WAIT_LAY_OFF});

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    layer_d = layer_q;
    cnt_d   = '0;

    unique case (state_q)
      IDLE: begin
        if (start && !valid_ctrl_busy && !layer_ctrl_busy) begin
          state_d = ISSUE_LOAD;
          tile_d  = '0;
          layer_d = '0;
        end
      end
      ISSUE_LOAD: state_d = WAIT_LOAD_ON;
      WAIT_LOAD_ON: begin
        if (valid_ctrl_busy)  state_d = WAIT_LOAD_OFF;
        else if (timed_out)   state_d = ERROR;
      end
      WAIT_LOAD_OFF: begin
        if (!valid_ctrl_busy && next_tile_ready) begin
          state_d = (tile_q == TW'(NUM_TILES - 1)) ? ISSUE_LAYER : NEXT_LOAD_TILE;
        end else if (timed_out) begin
          state_d = ERROR;
        end
      end
      NEXT_LOAD_TILE: begin
        tile_d  = tile_q + TW'(1);
        state_d = ISSUE_LOAD;
      end
      ISSUE_LAYER: state_d = WAIT_LAY_ON;
      WAIT_LAY_ON: begin
        if (layer_ctrl_busy)  state_d = WAIT_LAY_OFF;
        else if (timed_out)   state_d = ERROR;
      end
      WAIT_LAY_OFF: begin
        if (!layer_ctrl_busy) state_d = NEXT_LAYER;
        else if (timed_out)   state_d = ERROR;
      end
      NEXT_LAYER: begin
        if (layer_q == LW'(NUM_LAYERS - 1)) begin
          state_d = DONE;
        end else begin
          layer_d = layer_q + LW'(1);
          tile_d  = '0;
          state_d = ISSUE_LOAD;
        end
      end
      DONE:  state_d = IDLE;
      ERROR: if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort overrides every transition above, including a timeout.
    if (abort && (state_q != IDLE) && (state_q != ERROR)) begin
      state_d = IDLE;
      tile_d  = '0;
      layer_d = '0;
    end

    // Counter only runs while parked in the same wait state.
    if (in_wait && (state_d == state_q)) cnt_d = cnt_q + CW'(1);

    // Outputs are decoded from the next state so they are registered yet
    // line up with the cycle the sequencer sits in that state.
    load_d  = (state_d == ISSUE_LOAD);
    lay_d   = (state_d == ISSUE_LAYER);
    next_d  = (state_d == NEXT_LOAD_TILE);
    done_d  = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    error_d = (state_d == ERROR);
    mode_d  = 3'd0;
    unique case (state_d)
      ISSUE_LOAD, WAIT_LOAD_ON, WAIT_LOAD_OFF, NEXT_LOAD_TILE: mode_d = 3'd1;
      ISSUE_LAYER, WAIT_LAY_ON, WAIT_LAY_OFF, NEXT_LAYER, DONE: mode_d = 3'd2;
      ERROR:   mode_d = 3'd3;
      default: mode_d = 3'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tile_q  <= '0;
      layer_q <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      lay_q   <= 1'b0;
      next_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      error_q <= 1'b0;
      mode_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      lay_q   <= lay_d;
      next_q  <= next_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      error_q <= error_d;
      mode_q  <= mode_d;
    end
  end

  assign start_weights        = load_q;
  assign start_input          = load_q;
  assign start_valid_pipeline = load_q;
  assign start_layering       = lay_q;
  assign next_tile            = next_q;
  assign done                 = done_q;
  assign busy                 = busy_q;
  assign error                = error_q;
  assign mode                 = mode_q;
  assign tile_idx             = tile_q;
  assign layer_idx            = layer_q;

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// tb/tb_nn_seq_ctrl.sv - randomized self-checking bench for nn_seq_ctrl
//
// Purpose: two instances (A: 2 tiles x 2 layers, B: 1 tile x 1 layer with a
// short timeout) driven by randomized busy responders; observed pulse
// sequences are compared with the sequence the run rules predict.

module tb_nn_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2]     = '{1'b1, 1'b1};
  logic       start_s[2] = '{1'b0, 1'b0};
  logic       abort_s[2] = '{1'b0, 1'b0};
  logic       vbusy[2]   = '{1'b0, 1'b0};
  logic       lbusy[2]   = '{1'b0, 1'b0};
  logic       nready[2]  = '{1'b1, 1'b1};
  logic       sw[2], si[2], svp[2], slay[2], ntile[2], done_s[2], busy_s[2], err_s[2];
  logic [2:0] mode_s[2];
  logic       tidx[2], lidx[2];

  nn_seq_ctrl #(.N(8), .TILE(4), .NUM_LAYERS(2), .TIMEOUT(64)) u_a (
    .clk(clk), .rst(rst[0]), .start(start_s[0]), .abort(abort_s[0]),
    .valid_ctrl_busy(vbusy[0]), .layer_ctrl_busy(lbusy[0]), .next_tile_ready(nready[0]),
    .start_weights(sw[0]), .start_input(si[0]), .start_valid_pipeline(svp[0]),
    .start_layering(slay[0]), .next_tile(ntile[0]), .done(done_s[0]), .busy(busy_s[0]),
    .error(err_s[0]), .mode(mode_s[0]), .tile_idx(tidx[0]), .layer_idx(lidx[0])
  );

  nn_seq_ctrl #(.N(4), .TILE(4), .NUM_LAYERS(1), .TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst[1]), .start(start_s[1]), .abort(abort_s[1]),
    .valid_ctrl_busy(vbusy[1]), .layer_ctrl_busy(lbusy[1]), .next_tile_ready(nready[1]),
    .start_weights(sw[1]), .start_input(si[1]), .start_valid_pipeline(svp[1]),
    .start_layering(slay[1]), .next_tile(ntile[1]), .done(done_s[1]), .busy(busy_s[1]),
    .error(err_s[1]), .mode(mode_s[1]), .tile_idx(tidx[1]), .layer_idx(lidx[1])
  );

  int nt[2] = '{2, 1};
  int nl[2] = '{2, 1};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int evq[2][$];
  int base[2]  = '{0, 0};

  int vph[2]  = '{0, 0};
  int vdly[2] = '{0, 0};
  int vhl[2]  = '{0, 0};
  int lph[2]  = '{0, 0};
  int ldly[2] = '{0, 0};
  int lhl[2]  = '{0, 0};
  int rdy_cnt[2]   = '{0, 0};
  int rdy_hold[2]  = '{0, 0};
  int lhold[2]     = '{0, 0};
  int done_cyc[2]  = '{0, 0};
  int lfall_cyc[2] = '{0, 0};
  bit resp_en[2]   = '{1'b1, 1'b1};
  bit lforce[2]    = '{1'b0, 1'b0};

  function automatic int enc(int k, int t, int l, int m);
    return k * 1000 + t * 100 + l * 10 + m;
  endfunction

  task automatic check(string tag, int got, int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor plus busy-handshake responders for both instances.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (sw[d] | si[d] | svp[d])
        evq[d].push_back(enc((sw[d] & si[d] & svp[d]) ? 1 : 9, int'(tidx[d]), int'(lidx[d]), int'(mode_s[d])));
      if (ntile[d]) evq[d].push_back(enc(2, 0, 0, 0));
      if (slay[d])  evq[d].push_back(enc(3, 0, int'(lidx[d]), int'(mode_s[d])));
      if (done_s[d]) begin
        evq[d].push_back(enc(4, 0, 0, 0));
        done_cyc[d] = cyc;
      end
      if (rst[d] || !resp_en[d]) begin
        vph[d] = 0; lph[d] = 0; rdy_cnt[d] = 0;
      end else begin
        if (sw[d]) begin
          vph[d] = 1; vdly[d] = $urandom_range(0, 3);
        end else if (vph[d] == 1) begin
          if (vdly[d] == 0) begin vph[d] = 2; vhl[d] = $urandom_range(1, 4); end
          else vdly[d]--;
        end else if (vph[d] == 2) begin
          if (vhl[d] == 0) begin
            vph[d] = 0;
            rdy_cnt[d] = (rdy_hold[d] > 0) ? rdy_hold[d] : $urandom_range(0, 3);
          end else vhl[d]--;
        end
        if (slay[d]) begin
          lph[d] = 1; ldly[d] = $urandom_range(0, 3);
        end else if (lph[d] == 1) begin
          if (ldly[d] == 0) begin
            lph[d] = 2; lhl[d] = (lhold[d] > 0) ? lhold[d] : $urandom_range(1, 4);
          end else ldly[d]--;
        end else if (lph[d] == 2) begin
          if (lhl[d] == 0) begin lph[d] = 0; lfall_cyc[d] = cyc; end
          else lhl[d]--;
        end
      end
      vbusy[d]  = (vph[d] == 2);
      lbusy[d]  = (lph[d] == 2) || lforce[d];
      nready[d] = (rdy_cnt[d] == 0);
      if (rdy_cnt[d] > 0) rdy_cnt[d]--;
    end
  end

  task automatic start_op(int d);
    base[d] = evq[d].size();
    start_s[d] = 1'b1;
    @(negedge clk);
    start_s[d] = 1'b0;
    check("start_busy", int'(busy_s[d]), 1);
    check("start_mode", int'(mode_s[d]), 1);
    check("start_load_pulse", int'(sw[d]), 1);
  endtask

  task automatic finish_op(int d);
    int n;
    int exp_q[$];
    int got_n;
    n = 0;
    while (!done_s[d] && n < 3000) begin @(negedge clk); n++; end
    check("done_seen", int'(n < 3000), 1);
    repeat (3) @(negedge clk);
    check("end_busy", int'(busy_s[d]), 0);
    check("end_mode", int'(mode_s[d]), 0);
    check("end_tile_idx", int'(tidx[d]), nt[d] - 1);
    check("end_layer_idx", int'(lidx[d]), nl[d] - 1);
    check("done_latency", done_cyc[d] - lfall_cyc[d], 2);
    for (int l = 0; l < nl[d]; l++) begin
      for (int t = 0; t < nt[d]; t++) begin
        exp_q.push_back(enc(1, t, l, 1));
        if (t < nt[d] - 1) exp_q.push_back(enc(2, 0, 0, 0));
      end
      exp_q.push_back(enc(3, 0, l, 2));
    end
    exp_q.push_back(enc(4, 0, 0, 0));
    got_n = evq[d].size() - base[d];
    check("event_count", got_n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_n; i++)
      check("event_seq", evq[d][base[d] + i], exp_q[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int cnt;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", int'(busy_s[d]), 0);
      check("rst_mode", int'(mode_s[d]), 0);
      check("rst_error", int'(err_s[d]), 0);
      check("rst_tile_idx", int'(tidx[d]), 0);
      check("rst_layer_idx", int'(lidx[d]), 0);
      check("rst_pulses", int'(sw[d] | si[d] | svp[d] | slay[d] | ntile[d] | done_s[d]), 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Randomized well-behaved runs on A.
    for (int r = 0; r < 5; r++) begin
      start_op(0);
      finish_op(0);
    end

    // A start pulse while running must not re-enter.
    start_op(0);
    repeat (6) @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    finish_op(0);

    // next_tile_ready held low for 10 cycles after each load busy falls.
    rdy_hold[0] = 10;
    start_op(0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!vbusy[0] && n < 50);
    do begin @(negedge clk); #1; n++; end while (vbusy[0] && n < 100);
    check("stall_sync", int'(n < 100), 1);
    cnt = 0;
    repeat (9) begin @(negedge clk); if (ntile[0]) cnt++; end
    check("stall_no_next_tile", cnt, 0);
    check("stall_mode", int'(mode_s[0]), 1);
    finish_op(0);
    rdy_hold[0] = 0;

    // Abort while waiting for the layer engine to drop busy (layer 0).
    lhold[0] = 8;
    start_op(0);
    n = 0;
    while (!slay[0] && n < 500) begin @(negedge clk); n++; end
    check("abort_layer0", int'(lidx[0]), 0);
    do begin @(negedge clk); #1; n++; end while (!lbusy[0] && n < 520);
    @(negedge clk);
    abort_s[0] = 1'b1;
    @(negedge clk);
    abort_s[0] = 1'b0;
    check("abort_busy", int'(busy_s[0]), 0);
    check("abort_mode", int'(mode_s[0]), 0);
    check("abort_tile_idx", int'(tidx[0]), 0);
    check("abort_layer_idx", int'(lidx[0]), 0);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (done_s[0] || busy_s[0]) cnt++; end
    check("abort_quiet", cnt, 0);
    lhold[0] = 0;

    // Start with the layer engine busy is ignored.
    resp_en[0] = 1'b0;
    lforce[0]  = 1'b1;
    repeat (2) @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    check("blocked_load_pulse", int'(sw[0]), 0);
    check("blocked_busy", int'(busy_s[0]), 0);
    @(negedge clk);
    check("blocked_mode", int'(mode_s[0]), 0);
    lforce[0]  = 1'b0;
    resp_en[0] = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-operation while waiting for load busy to drop.
    start_op(0);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!vbusy[0] && n < 50);
    @(negedge clk);
    check("pre_rst_busy", int'(busy_s[0]), 1);
    rst[0] = 1'b1;
    #1;
    check("midrst_busy", int'(busy_s[0]), 0);
    check("midrst_mode", int'(mode_s[0]), 0);
    check("midrst_idx", int'(tidx[0] | lidx[0]), 0);
    check("midrst_flags", int'(err_s[0] | sw[0] | si[0] | svp[0] | slay[0] | ntile[0] | done_s[0]), 0);
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (2) @(negedge clk);
    start_op(0);
    finish_op(0);

    // Single tile, single layer instance.
    start_op(1);
    finish_op(1);

    // Timeout: load busy never rises on B.
    resp_en[1] = 1'b0;
    @(negedge clk);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    check("to_load_pulse", int'(sw[1]), 1);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (err_s[1]) break;
      n++;
    end
    check("to_wait_cycles", n, 16);
    check("to_mode", int'(mode_s[1]), 3);
    check("to_busy", int'(busy_s[1]), 1);
    repeat (5) @(negedge clk);
    check("to_sticky", int'(err_s[1]), 1);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    check("to_clear_error", int'(err_s[1]), 0);
    check("to_clear_mode", int'(mode_s[1]), 0);
    check("to_clear_busy", int'(busy_s[1]), 0);
    resp_en[1] = 1'b1;
    repeat (2) @(negedge clk);
    start_op(1);
    finish_op(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
